// File: rtl/mem_requester.sv
// CPU-side initiator for memory_controller: queues core load/store requests,
// issues them one at a time and returns in-order responses over valid/ready.
module mem_requester #(
    parameter int BUS_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BUS_WIDTH-1:0] req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_is_write,
    output logic [BUS_WIDTH-1:0] rsp_rdata,
    output logic [2:0]           mc_write_read,
    output logic [BUS_WIDTH-1:0] mc_addr,
    output logic [BUS_WIDTH-1:0] mc_write_data,
    input  logic [BUS_WIDTH-1:0] mc_read_data,
    input  logic                 mc_busy,
    output logic                 proto_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]           r_state;
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic                 r_fifo_we   [FIFO_DEPTH];
    logic [BUS_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [BUS_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic                 r_we;
    logic [BUS_WIDTH-1:0] r_mc_addr;
    logic [BUS_WIDTH-1:0] r_mc_wdata;
    logic                 r_rsp_valid;
    logic                 r_rsp_is_write;
    logic [BUS_WIDTH-1:0] r_rsp_rdata;
    logic                 r_proto_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_slot_free;
    logic w_start;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push      = req_valid && !w_full;
    assign w_pop       = (r_state == S_CAPTURE);
    assign w_slot_free = !r_rsp_valid || rsp_ready;
    assign w_start     = (r_state == S_IDLE) && !w_empty && w_slot_free && !mc_busy;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr[AW-1:0]]   <= req_we;
            r_fifo_addr[r_wr_ptr[AW-1:0]] <= req_addr;
            r_fifo_data[r_wr_ptr[AW-1:0]] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_start) r_state <= S_ISSUE;
                S_ISSUE:   r_state <= S_CAPTURE;
                S_CAPTURE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Command fields are latched on issue and held through capture and beyond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_mc_addr  <= '0;
            r_mc_wdata <= '0;
        end else if (w_start) begin
            r_we       <= r_fifo_we[r_rd_ptr[AW-1:0]];
            r_mc_addr  <= r_fifo_addr[r_rd_ptr[AW-1:0]];
            r_mc_wdata <= r_fifo_we[r_rd_ptr[AW-1:0]] ? r_fifo_data[r_rd_ptr[AW-1:0]] : '0;
        end
    end

    // A response loading in the same cycle as a handshake keeps rsp_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_is_write <= 1'b0;
            r_rsp_rdata    <= '0;
        end else if (w_pop) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_is_write <= r_we;
            r_rsp_rdata    <= r_we ? '0 : mc_read_data;
        end else if (rsp_ready) begin
            r_rsp_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_proto_err <= 1'b0;
        else if (w_pop && !mc_busy) r_proto_err <= 1'b1;
    end

    assign req_ready     = !w_full;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_is_write  = r_rsp_is_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign mc_write_read = (r_state == S_ISSUE) ? (r_we ? 3'b010 : 3'b001) : 3'b000;
    assign mc_addr       = r_mc_addr;
    assign mc_write_data = r_mc_wdata;
    assign proto_err     = r_proto_err;

endmodule
